// File: rtl/fpu_result_collector.sv
// Collects fadd results: tracks issues through a fixed-latency shadow pipeline,
// queues {y, tag, class flags} in a FIFO and returns them over valid/ready.
module fpu_result_collector #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DEPTH   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_issue_valid,
    input  logic [TAG_W-1:0] i_issue_tag,
    input  logic [31:0]      i_y,
    output logic             o_credit_ok,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_out_data,
    output logic [TAG_W-1:0] o_out_tag,
    output logic [3:0]       o_out_flags,
    output logic             o_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = $clog2(LATENCY + DEPTH + 1);

    logic [LATENCY-1:0] r_v;
    logic [TAG_W-1:0]   r_tag [LATENCY];

    logic [31:0]        r_mem_data  [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag   [DEPTH];
    logic [3:0]         r_mem_flags [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    logic [7:0]         w_exp;
    logic [22:0]        w_man;
    logic [3:0]         w_flags;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_wr;
    logic [SUM_W-1:0]   w_inflight;

    // Shadow pipeline: v bits are cleared by reset so pre-reset issues never land.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v <= '0;
        end else begin
            r_v[0] <= i_issue_valid;
            for (int k = 1; k < LATENCY; k++) begin
                r_v[k] <= r_v[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        r_tag[0] <= i_issue_tag;
        for (int k = 1; k < LATENCY; k++) begin
            r_tag[k] <= r_tag[k-1];
        end
    end

    assign w_exp = i_y[30:23];
    assign w_man = i_y[22:0];

    always_comb begin
        w_flags    = 4'b0000;
        w_flags[3] = (w_exp == 8'hFF) && (w_man != '0);
        w_flags[2] = (w_exp == 8'hFF) && (w_man == '0);
        w_flags[1] = (w_exp == 8'h00) && (w_man == '0);
        w_flags[0] = (w_exp == 8'h00) && (w_man != '0);
    end

    assign w_push = r_v[LATENCY-1];
    assign w_pop  = o_out_valid && i_out_ready;
    assign w_full = (r_count == CNT_W'(DEPTH));
    // A full FIFO still accepts when the head leaves on the same edge.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem_data[r_wr_ptr]  <= i_y;
            r_mem_tag[r_wr_ptr]   <= r_tag[LATENCY-1];
            r_mem_flags[r_wr_ptr] <= w_flags;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < LATENCY; k++) begin
            w_inflight = w_inflight + SUM_W'(r_v[k]);
        end
    end

    assign o_credit_ok = (w_inflight + SUM_W'(r_count)) < SUM_W'(DEPTH);
    assign o_out_valid = (r_count != '0);
    assign o_out_data  = o_out_valid ? r_mem_data[r_rd_ptr]  : '0;
    assign o_out_tag   = o_out_valid ? r_mem_tag[r_rd_ptr]   : '0;
    assign o_out_flags = o_out_valid ? r_mem_flags[r_rd_ptr] : '0;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Scoreboard bench for fpu_result_collector: a queue-based model of the result
// FIFO predicts every beat, credit and overflow; a negedge monitor compares.
module tb_fpu_result_collector;

    localparam int unsigned LATENCY = 2;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned DEPTH   = 4;

    typedef struct {
        int unsigned      due;
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
    } pend_t;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [3:0]       flags;
    } beat_t;

    logic             clk;
    logic             i_rst;
    logic             i_issue_valid;
    logic [TAG_W-1:0] i_issue_tag;
    logic [31:0]      i_y;
    logic             o_credit_ok;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [31:0]      o_out_data;
    logic [TAG_W-1:0] o_out_tag;
    logic [3:0]       o_out_flags;
    logic             o_overflow;

    pend_t       pending[$];
    beat_t       sb[$];
    logic        exp_ovf;
    int unsigned cyc;
    int          n_checks;
    int          n_fail;
    int          n_beats;
    int unsigned first_pop;
    int unsigned last_pop;
    logic [TAG_W-1:0] last_tag;
    logic        mon_en;

    fpu_result_collector #(
        .LATENCY(LATENCY),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_issue_valid(i_issue_valid),
        .i_issue_tag  (i_issue_tag),
        .i_y          (i_y),
        .o_credit_ok  (o_credit_ok),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data),
        .o_out_tag    (o_out_tag),
        .o_out_flags  (o_out_flags),
        .o_overflow   (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] classify(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        e = v[30:23];
        m = v[22:0];
        if (e == 8'hFF) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 8'h00) return (m == 0) ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, then advance the model.
    task automatic step(input logic iv, input logic [TAG_W-1:0] tag, input logic [31:0] yv,
                        input logic rdy, input logic rst);
        pend_t p;
        i_issue_valid = iv;
        i_issue_tag   = tag;
        i_out_ready   = rdy;
        i_rst         = rst;
        if (pending.size() != 0 && pending[0].due == cyc + 1) i_y = pending[0].y;
        else i_y = $urandom();
        @(posedge clk);
        cyc++;
        if (rst) begin
            pending.delete();
            sb.delete();
            exp_ovf = 1'b0;
        end else begin
            if (pending.size() != 0 && pending[0].due == cyc) begin
                p = pending.pop_front();
                // A pop on this edge was already removed by the monitor.
                if (sb.size() < DEPTH) sb.push_back('{p.y, p.tag, classify(p.y)});
                else exp_ovf = 1'b1;
            end
            if (iv) pending.push_back('{cyc + LATENCY, yv, tag});
        end
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 32'h0, rdy, 1'b0);
    endtask

    function automatic logic [31:0] rand_y();
        logic [31:0] v;
        v = $urandom();
        case ($urandom_range(0, 5))
            0: v[30:23] = 8'hFF;
            1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            2: begin v[30:23] = 8'h00; v[22:0] = '0; end
            3: begin v[30:23] = 8'h00; v[22:0] = 23'($urandom_range(1, 32'h7FFFFF)); end
            default: ;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(o_out_valid), 32'(sb.size() != 0));
            chk("credit_ok", 32'(o_credit_ok), 32'((pending.size() + sb.size()) < DEPTH));
            chk("overflow", 32'(o_overflow), 32'(exp_ovf));
            if (o_out_valid && sb.size() != 0) begin
                chk("out_data", o_out_data, sb[0].data);
                chk("out_tag", 32'(o_out_tag), 32'(sb[0].tag));
                chk("out_flags", 32'(o_out_flags), 32'(sb[0].flags));
                if (i_out_ready) begin
                    void'(sb.pop_front());
                    if (n_beats == 0) first_pop = cyc + 1;
                    last_pop = cyc + 1;
                    last_tag = o_out_tag;
                    n_beats++;
                end
            end else if (!o_out_valid) begin
                chk("idle_data", o_out_data, 32'h0);
                chk("idle_tag_flags", {20'h0, o_out_tag, o_out_flags}, 32'h0);
            end
        end
    end

    logic [31:0] stream_y [8];
    int          n_issued;
    logic        iv;

    initial begin
        stream_y = '{32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000,
                     32'h00000001, 32'h3F800000, 32'hFF800000, 32'h40000000};
        n_checks = 0; n_fail = 0; n_beats = 0; cyc = 0;
        first_pop = 0; last_pop = 0; last_tag = '0;
        exp_ovf = 1'b0; mon_en = 1'b0;
        i_rst = 1'b1; i_issue_valid = 1'b0; i_issue_tag = '0; i_y = '0; i_out_ready = 1'b0;

        step(1'b0, '0, 32'h0, 1'b0, 1'b1);
        step(1'b0, '0, 32'h0, 1'b0, 1'b1);
        mon_en = 1'b1;
        idle(1, 1'b0);

        // Single result
        n_beats = 0;
        step(1'b1, TAG_W'(3), 32'h40400000, 1'b1, 1'b0);
        idle(LATENCY + 3, 1'b1);
        chk("single_beats", 32'(n_beats), 32'd1);

        // Back-to-back stream
        n_beats = 0;
        for (int i = 0; i < 8; i++) step(1'b1, TAG_W'(i), stream_y[i], 1'b1, 1'b0);
        idle(LATENCY + 4, 1'b1);
        chk("stream_beats", 32'(n_beats), 32'd8);
        chk("stream_no_gaps", last_pop - first_pop, 32'd7);

        // Backpressure and credit
        n_issued = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            iv = o_credit_ok;
            step(iv, TAG_W'(n_issued), rand_y(), 1'b0, 1'b0);
            if (iv) n_issued++;
        end
        chk("credit_issues", 32'(n_issued), DEPTH);
        chk("credit_low_full", 32'(o_credit_ok), 32'd0);
        idle(DEPTH + 3, 1'b1);
        chk("credit_back", 32'(o_credit_ok), 32'd1);

        // Forced overflow
        n_beats = 0;
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, TAG_W'(i), rand_y(), 1'b0, 1'b0);
        idle(LATENCY + 1, 1'b0);
        chk("overflow_set", 32'(o_overflow), 32'd1);
        idle(DEPTH + 3, 1'b1);
        chk("overflow_beats", 32'(n_beats), DEPTH);
        chk("overflow_sticky", 32'(o_overflow), 32'd1);

        // Full with simultaneous push/pop
        step(1'b0, '0, 32'h0, 1'b0, 1'b1);
        n_beats = 0;
        for (int i = 0; i < DEPTH; i++) step(1'b1, TAG_W'(i), rand_y(), 1'b0, 1'b0);
        step(1'b1, TAG_W'(9), 32'h3F800000, 1'b0, 1'b0);
        idle(LATENCY - 1, 1'b0);
        step(1'b0, '0, 32'h0, 1'b1, 1'b0);
        idle(1, 1'b0);
        chk("fullpp_no_ovf", 32'(o_overflow), 32'd0);
        idle(DEPTH + 2, 1'b1);
        chk("fullpp_beats", 32'(n_beats), DEPTH + 1);
        chk("fullpp_last_tag", 32'(last_tag), 32'd9);

        // Reset mid-flight: the reset edge coincides with the first landing
        n_beats = 0;
        step(1'b1, TAG_W'(1), rand_y(), 1'b1, 1'b0);
        step(1'b1, TAG_W'(2), rand_y(), 1'b1, 1'b0);
        step(1'b1, TAG_W'(5), rand_y(), 1'b1, 1'b1);
        idle(LATENCY + 2, 1'b1);
        chk("rst_no_beats", 32'(n_beats), 32'd0);
        chk("rst_credit", 32'(o_credit_ok), 32'd1);
        step(1'b1, TAG_W'(7), 32'hC0000000, 1'b1, 1'b0);
        idle(LATENCY + 2, 1'b1);
        chk("rst_after_beats", 32'(n_beats), 32'd1);

        // Randomized traffic, mostly credit-obeying
        step(1'b0, '0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            iv = ($urandom_range(0, 9) < 8) ? (o_credit_ok && $urandom_range(0, 3) != 0)
                                            : 1'($urandom());
            step(iv, TAG_W'($urandom()), rand_y(), 1'($urandom_range(0, 2) != 0), 1'b0);
        end
        idle(DEPTH + LATENCY + 4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
